multi_cycle_control_unit: RTL and testbench

Moore-style control FSM for the multi-cycle MIPS datapath. It sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath select and write-enable, including the immediate-extender mode (ExtSel), register-file writes, data-memory strobes and PC update. It sits beside the datapath top level. It consumes the IR opcode and the ALU flags, and no other datapath logic makes control decisions.

---
 rtl/cu_pkg.sv | 45 ++++
 rtl/cu_decoder.sv | 26 ++
 rtl/multi_cycle_control_unit.sv | 117 +++++++++++
 tb/tb_multi_cycle_control_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, FSM state encodings and ALU operation codes shared by the control unit
package cu_pkg;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XORI  = 6'b010100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // HALT sits outside the 3-bit debug range so State reads 000 while halted
    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_AL = 4'd2;
    localparam logic [3:0] S_EXE_BR = 4'd3;
    localparam logic [3:0] S_EXE_LS = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB_AL  = 4'd6;
    localparam logic [3:0] S_WB_LD  = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;

    function automatic logic is_alu_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_ADDIU, OP_SUB, OP_ANDI, OP_AND, OP_ORI, OP_OR, OP_XORI, OP_SLL, OP_SLTI};
    endfunction
endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode decode of datapath selects, ungated by state
// Ports: op (IR opcode) in; ext_sel, alu_src_a, alu_src_b, alu_op, reg_dst out
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] op,
    output logic       ext_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst
);
    always_comb begin
        ext_sel   = op inside {OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
        alu_src_a = op == OP_SLL;
        alu_src_b = op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW, OP_SW};
        alu_op    = op inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ} ? ALU_SUB :
                    op inside {OP_AND, OP_ANDI}                ? ALU_AND :
                    op inside {OP_OR, OP_ORI}                  ? ALU_OR  :
                    op == OP_XORI                              ? ALU_XOR :
                    op == OP_SLL                               ? ALU_SLL :
                    op == OP_SLTI                              ? ALU_SLT : ALU_ADD;
        reg_dst   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL}             ? 2'b10 :
                    op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW} ? 2'b01 : 2'b00;
    end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: Moore FSM sequencing IF/ID/EXE/MEM/WB for the multi-cycle MIPS datapath
// Inputs: CLK, Reset (async active-low), OpCode, Funct, Zero, Sign
// Outputs: PC/IR/memory strobes, datapath selects, ALUOp, PCSrc, State (debug)
// Build option: CU_HALT_EN adds a HALT state entered on opcode 111111
module multi_cycle_control_unit
    import cu_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc,
    output logic [2:0] State
);
    logic [3:0] state_q, state_d;
    logic       run_q;
    logic       dec_ext, dec_sa, dec_sb;
    logic [2:0] dec_aop;
    logic [1:0] dec_rd;
    logic       is_jump, is_jal, is_jr, is_br, is_lw, is_sw, is_halt, alu_ok, taken, unused_funct;
    logic       in_if, in_id, in_exe, in_br, in_mem, in_wbal, in_wbld;

    cu_decoder u_dec (
        .op       (OpCode),
        .ext_sel  (dec_ext),
        .alu_src_a(dec_sa),
        .alu_src_b(dec_sb),
        .alu_op   (dec_aop),
        .reg_dst  (dec_rd)
    );

    // every instruction class is identified by its own opcode, so Funct carries no control information
    assign unused_funct = ^Funct;

    always_comb begin
        is_jal  = OpCode == OP_JAL;
        is_jr   = OpCode == OP_JR;
        is_jump = is_jal | is_jr | (OpCode == OP_J);
        is_br   = OpCode inside {OP_BEQ, OP_BNE, OP_BLTZ};
        is_lw   = OpCode == OP_LW;
        is_sw   = OpCode == OP_SW;
`ifdef CU_HALT_EN
        is_halt = OpCode == OP_HALT;
`else
        is_halt = 1'b0;
`endif
        alu_ok  = is_alu_op(OpCode);
        taken   = (OpCode == OP_BEQ & Zero) | (OpCode == OP_BNE & ~Zero) | (OpCode == OP_BLTZ & Sign);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID:     state_d = is_jump ? S_IF : is_br ? S_EXE_BR : (is_lw | is_sw) ? S_EXE_LS :
                                is_halt ? S_HALT : S_EXE_AL;
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_AL:  state_d = S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = state_q == S_HALT ? S_HALT : S_IF;
        endcase
    end

    // run_q holds the FSM idle until the first edge after Reset releases, so that edge opens IF
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= run_q ? state_d : state_q;
        end
    end

    always_comb begin
        in_if     = run_q & (state_q == S_IF);
        in_id     = state_q == S_ID;
        in_exe    = state_q inside {S_EXE_AL, S_EXE_BR, S_EXE_LS};
        in_br     = state_q == S_EXE_BR;
        in_mem    = state_q == S_MEM;
        in_wbal   = state_q == S_WB_AL;
        in_wbld   = state_q == S_WB_LD;
        PCWre     = (in_id & is_jump) | in_br | (in_mem & is_sw) | in_wbal | in_wbld;
        IRWre     = in_if;
        InsMemRW  = in_if;
        ExtSel    = in_exe & dec_ext;
        ALUSrcA   = in_exe & dec_sa;
        ALUSrcB   = in_exe & dec_sb;
        ALUOp     = in_exe ? dec_aop : ALU_ADD;
        RegWre    = (in_id & is_jal) | (in_wbal & alu_ok) | in_wbld;
        RegDst    = in_wbld ? 2'b01 : (in_wbal & alu_ok) ? dec_rd : 2'b00;
        WrRegDSrc = (in_wbal & alu_ok) | in_wbld;
        mRD       = in_mem & is_lw;
        mWR       = in_mem & is_sw;
        DBDataSrc = in_wbld;
        PCSrc     = (in_id & is_jr) ? 2'b10 : (in_id & is_jump) ? 2'b11 : (in_br & taken) ? 2'b01 : 2'b00;
        State     = state_q[2:0];
    end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed instruction sequences checked against hand-computed control vectors
module tb_multi_cycle_control_unit;
    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] OpCode = 6'b000001;
    logic [5:0] Funct = 6'b0;
    logic       Zero = 1'b0;
    logic       Sign = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, WrRegDSrc, RegWre, mRD, mWR, DBDataSrc;
    logic [2:0] ALUOp, State;
    logic [1:0] RegDst, PCSrc;
    logic [20:0] obs;
    int total = 0;
    int bad = 0;

    multi_cycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .Sign(Sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .State(State)
    );

    always #5 CLK = ~CLK;

    assign obs = {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst,
                  WrRegDSrc, RegWre, mRD, mWR, DBDataSrc, PCSrc, State};

    function automatic logic [20:0] cv(input logic pcw, irw, imr, ext, sa, sb, input logic [2:0] aop,
                                       input logic [1:0] rd, input logic wrs, rw, mrd, mwr, dbs,
                                       input logic [1:0] pcs, input logic [2:0] st);
        return {pcw, irw, imr, ext, sa, sb, aop, rd, wrs, rw, mrd, mwr, dbs, pcs, st};
    endfunction

    task automatic chk(input string tag, input logic [20:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic step(input string tag, input logic [20:0] e);
        @(posedge CLK);
        #2;
        chk(tag, e);
    endtask

    logic [20:0] v_if, v_id, v_zero;

    initial begin
        v_if   = cv(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        v_id   = cv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        v_zero = '0;
        repeat (2) @(posedge CLK);
        #2;
        chk("reset_outputs", v_zero);
        Reset = 1'b1;
        #1;
        chk("released_idle", v_zero);
        step("addiu_if", v_if);
        step("addiu_id", v_id);
        step("addiu_exe", cv(0,0,0,1,0,1,0,0,0,0,0,0,0,0,2));
        step("addiu_wb", cv(1,0,0,0,0,0,0,1,1,1,0,0,0,0,6));
        step("ori_if", v_if);
        OpCode = 6'b010010;
        step("ori_id", v_id);
        step("ori_exe", cv(0,0,0,0,0,1,3,0,0,0,0,0,0,0,2));
        step("ori_wb", cv(1,0,0,0,0,0,0,1,1,1,0,0,0,0,6));
        step("sll_if", v_if);
        OpCode = 6'b011000;
        step("sll_id", v_id);
        step("sll_exe", cv(0,0,0,0,1,0,5,0,0,0,0,0,0,0,2));
        step("sll_wb", cv(1,0,0,0,0,0,0,2,1,1,0,0,0,0,6));
        step("lw_if", v_if);
        OpCode = 6'b110001;
        step("lw_id", v_id);
        step("lw_exe", cv(0,0,0,1,0,1,0,0,0,0,0,0,0,0,4));
        step("lw_mem", cv(0,0,0,0,0,0,0,0,0,0,1,0,0,0,5));
        step("lw_wb", cv(1,0,0,0,0,0,0,1,1,1,0,0,1,0,7));
        step("sw_if", v_if);
        OpCode = 6'b110000;
        step("sw_id", v_id);
        step("sw_exe", cv(0,0,0,1,0,1,0,0,0,0,0,0,0,0,4));
        step("sw_mem", cv(1,0,0,0,0,0,0,0,0,0,0,1,0,0,5));
        step("beq_if", v_if);
        OpCode = 6'b110100;
        Zero = 1'b1;
        step("beq_id", v_id);
        step("beq_taken", cv(1,0,0,1,0,0,1,0,0,0,0,0,0,1,3));
        step("beq2_if", v_if);
        Zero = 1'b0;
        step("beq2_id", v_id);
        step("beq_not_taken", cv(1,0,0,1,0,0,1,0,0,0,0,0,0,0,3));
        step("bne_if", v_if);
        OpCode = 6'b110101;
        step("bne_id", v_id);
        step("bne_taken", cv(1,0,0,1,0,0,1,0,0,0,0,0,0,1,3));
        step("bltz_if", v_if);
        OpCode = 6'b110110;
        Sign = 1'b1;
        step("bltz_id", v_id);
        step("bltz_taken", cv(1,0,0,0,0,0,1,0,0,0,0,0,0,1,3));
        step("jal_if", v_if);
        Sign = 1'b0;
        OpCode = 6'b111010;
        step("jal_id", cv(1,0,0,0,0,0,0,0,0,1,0,0,0,3,1));
        step("jr_if", v_if);
        OpCode = 6'b111001;
        step("jr_id", cv(1,0,0,0,0,0,0,0,0,0,0,0,0,2,1));
        step("nop_if", v_if);
        OpCode = 6'b101010;
        step("nop_id", v_id);
        step("nop_exe", cv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,2));
        step("nop_wb", cv(1,0,0,0,0,0,0,0,0,0,0,0,0,0,6));
        step("swr_if", v_if);
        OpCode = 6'b110000;
        step("swr_id", v_id);
        step("swr_exe", cv(0,0,0,1,0,1,0,0,0,0,0,0,0,0,4));
        step("swr_mem", cv(1,0,0,0,0,0,0,0,0,0,0,1,0,0,5));
        #1;
        Reset = 1'b0;
        #1;
        chk("rst_mid_mem", v_zero);
        @(posedge CLK);
        #2;
        chk("rst_held", v_zero);
        Reset = 1'b1;
        step("after_rst_if", v_if);
        OpCode = 6'b111111;
        step("op3f_id", v_id);
`ifdef CU_HALT_EN
        for (int i = 0; i < 20; i++) step("halt_hold", v_zero);
`else
        step("op3f_nop_exe", cv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,2));
        step("op3f_nop_wb", cv(1,0,0,0,0,0,0,0,0,0,0,0,0,0,6));
        step("op3f_next_if", v_if);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
